// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM state type and flag-vector layout for the sequential ALU.
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL, OP_SRL, OP_SRA,
    OP_MUL, OP_DIVU, OP_REMU
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef struct packed {
    logic carry;
    logic ovf;
    logic dz;
  } flags_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result handshake bundle between a requester (master) and the ALU (slave).
interface alu_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             greater_flag;
  logic             carry_flag;
  logic             ovf_flag;
  logic             dz_flag;
  modport master (
    output in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero_flag, greater_flag, carry_flag, ovf_flag, dz_flag
  );
  modport slave (
    input  in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero_flag, greater_flag, carry_flag, ovf_flag, dz_flag
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider over WIDTH cycles.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             div,
  input  logic             rem,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);
  localparam int CW = $clog2(WIDTH);
  logic             busy, div_q, rem_q, ge;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, x, y, acc_n, x_n, y_n, rs;
  logic [WIDTH:0]   r;
  // acc: product or partial remainder; x: multiplier or dividend/quotient; y: multiplicand or divisor
  always_comb begin
    r = {acc, x[WIDTH-1]};
    ge = r >= {1'b0, y};
    rs = ge ? r[WIDTH-1:0] - y : r[WIDTH-1:0];
    acc_n = div_q ? rs : acc + (x[0] ? y : '0);
    x_n = div_q ? {x[WIDTH-2:0], ge} : x >> 1;
    y_n = div_q ? y : y << 1;
  end
  assign done = busy && cnt == CW'(WIDTH - 1);
  assign res = div_q && !rem_q ? x_n : acc_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      cnt <= '0;
      acc <= '0;
      x <= '0;
      y <= '0;
      div_q <= 1'b0;
      rem_q <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      acc <= '0;
      x <= a;
      y <= b;
      div_q <= div;
      rem_q <= rem;
    end else if (busy) begin
      acc <= acc_n;
      x <= x_n;
      y <= y_n;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; single-cycle ops finish in one cycle, MUL/DIVU/REMU iterate WIDTH cycles.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MULDIV_EN = 1
) (
  input  logic clk,
  input  logic rst_n,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  state_e           state, state_n;
  op_e              op;
  flags_t           flg_q, alu_flg;
  logic [WIDTH-1:0] res_q, alu_res, md_res, a, b;
  logic [WIDTH:0]   sum, diff;
  logic             accept, is_md, is_iter, md_done;
  assign op = op_e'(bus.op);
  assign a = bus.src_a;
  assign b = bus.src_b;
  assign accept = bus.in_valid && bus.in_ready;
  assign is_md = MULDIV_EN != 0 && (op == OP_MUL || op == OP_DIVU || op == OP_REMU);
  // a zero divisor short-circuits to the single-cycle path
  assign is_iter = is_md && (op == OP_MUL || b != '0);
  assign sum = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  always_comb begin
    alu_res = '0;
    alu_flg = '0;
    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_flg.carry = sum[WIDTH];
        alu_flg.ovf = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_flg.carry = !diff[WIDTH];
        alu_flg.ovf = a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1];
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLL: alu_res = a << b[SW-1:0];
      OP_SRL: alu_res = a >> b[SW-1:0];
      OP_SRA: alu_res = $unsigned($signed(a) >>> b[SW-1:0]);
      OP_DIVU: begin
        alu_res = is_md ? '1 : '0;
        alu_flg.dz = is_md;
      end
      OP_REMU: begin
        alu_res = is_md ? a : '0;
        alu_flg.dz = is_md;
      end
      default: ;
    endcase
  end
  alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_iter),
    .div   (op != OP_MUL),
    .rem   (op == OP_REMU),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .res   (md_res)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  always_comb
    state_n = state == S_IDLE ? (accept ? (is_iter ? S_BUSY : S_DONE) : S_IDLE)
            : state == S_BUSY ? (md_done ? S_DONE : S_BUSY)
            : (bus.out_ready ? S_IDLE : S_DONE);
  always_comb begin
    bus.in_ready = state == S_IDLE;
    bus.out_valid = state == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res_q <= '0;
      flg_q <= '0;
    end else if (accept) begin
      res_q <= is_iter ? res_q : alu_res;
      flg_q <= is_iter ? '0 : alu_flg;
    end else if (state == S_BUSY && md_done) begin
      res_q <= md_res;
    end
  assign bus.result = res_q;
  assign bus.zero_flag = res_q == '0;
  assign bus.greater_flag = !res_q[WIDTH-1];
  assign bus.carry_flag = flg_q.carry;
  assign bus.ovf_flag = flg_q.ovf;
  assign bus.dz_flag = flg_q.dz;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq (WIDTH=32, MULDIV_EN=1).
module tb_alu_seq;
  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        c, v, d;
    int          lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq #(.WIDTH(32), .MULDIV_EN(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic c, input logic v, input logic d,
                      input int lat, input string tag);
    exp_t e;
    int   n;
    logic rdy_seen;
    e.tag = tag; e.res = r; e.c = c; e.v = v; e.d = d; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1;
    // keep junk requests on the bus while busy/done; they must be ignored
    bus.op = 4'($urandom); bus.src_a = $urandom; bus.src_b = $urandom;
    n = 1;
    rdy_seen = 1'b0;
    while (!bus.out_valid && n < 100) begin
      rdy_seen |= bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    chk({e.tag, "_latency"}, n, e.lat);
    if (e.lat > 1) chk({e.tag, "_busy_in_ready"}, {31'b0, rdy_seen}, 32'd0);
    chk({e.tag, "_result"}, bus.result, e.res);
    chk({e.tag, "_zero"}, {31'b0, bus.zero_flag}, {31'b0, e.res == 32'd0});
    chk({e.tag, "_greater"}, {31'b0, bus.greater_flag}, {31'b0, ~e.res[31]});
    chk({e.tag, "_carry"}, {31'b0, bus.carry_flag}, {31'b0, e.c});
    chk({e.tag, "_ovf"}, {31'b0, bus.ovf_flag}, {31'b0, e.v});
    chk({e.tag, "_dz"}, {31'b0, bus.dz_flag}, {31'b0, e.d});
  endtask
  task automatic ack(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk({tag, "_ack_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({tag, "_ack_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
  endtask
  task automatic check_reset_state(input string tag);
    chk({tag, "_result"}, bus.result, 32'd0);
    chk({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    chk({tag, "_flags"}, {27'b0, bus.zero_flag, bus.greater_flag, bus.carry_flag, bus.ovf_flag, bus.dz_flag},
        32'b11000);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0; bus.op = 4'd0; bus.src_a = 32'd0; bus.src_b = 32'd0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    send(4'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1, "add_ovf");  ack("add_ovf");
    send(4'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0, 1, "add_carry");        ack("add_carry");
    send(4'd1, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 1, "sub_eq");                 ack("sub_eq");
    send(4'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1, "sub_borrow");      ack("sub_borrow");
    send(4'd1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1, "sub_ovf"); ack("sub_ovf");
    send(4'd5, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1, "slt_neg");         ack("slt_neg");
    send(4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1, "and"); ack("and");
    send(4'd3, 32'h0000F0F0, 32'h0F000000, 32'h0F00F0F0, 1'b0, 1'b0, 1'b0, 1, "or");  ack("or");
    send(4'd6, 32'd1, 32'd31, 32'h80000000, 1'b0, 1'b0, 1'b0, 1, "sll");             ack("sll");
    send(4'd7, 32'h80000000, 32'h24, 32'h08000000, 1'b0, 1'b0, 1'b0, 1, "srl");      ack("srl");
    send(4'd8, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0, 1'b0, 1, "sra");       ack("sra");
    send(4'd13, 32'h1234, 32'h5678, 32'd0, 1'b0, 1'b0, 1'b0, 1, "undef_op");         ack("undef_op");
    send(4'd9, 32'h00010000, 32'h00010000, 32'd0, 1'b0, 1'b0, 1'b0, 33, "mul_wrap"); ack("mul_wrap");
    send(4'd9, 32'd12345, 32'd1000, 32'd12345000, 1'b0, 1'b0, 1'b0, 33, "mul");      ack("mul");
    send(4'd10, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b0, 33, "divu");               ack("divu");
    send(4'd11, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0, 33, "remu");                ack("remu");
    send(4'd10, 32'hFFFFFFFF, 32'd3, 32'h55555555, 1'b0, 1'b0, 1'b0, 33, "divu_big"); ack("divu_big");
    send(4'd10, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1, "divu_dz");         ack("divu_dz");
    send(4'd11, 32'd9, 32'd0, 32'd9, 1'b0, 1'b0, 1'b1, 1, "remu_dz");                ack("remu_dz");
    send(4'd4, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1'b0, 1'b0, 1'b0, 1, "xor_hold");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.op = 4'($urandom); bus.src_a = $urandom; bus.src_b = $urandom;
      chk("xor_hold_result", bus.result, 32'h0000FF00);
      chk("xor_hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("xor_hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    ack("xor_hold");
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'd10; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_busy", {31'b0, bus.in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_mid_no_output", {31'b0, bus.out_valid}, 32'd0);
    send(4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1, "post_rst_add"); ack("post_rst_add");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64).
REQ-002 SHALL have parameter MULDIV_EN, default 1, enabling the iterative MUL/DIVU/REMU ops.
REQ-003 SHALL have port clk  input  1  single clock; all state rises on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op  input  4  operation code.
REQ-008 SHALL have port src_a  input  WIDTH  operand A.
REQ-009 SHALL have port src_b  input  WIDTH  operand B.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  operation result.
REQ-013 SHALL have port zero_flag  output  1  result == 0.
REQ-014 SHALL have port greater_flag  output  1  result MSB == 0.
REQ-015 SHALL have port carry_flag  output  1  carry out (ADD) / no-borrow (SUB), else 0.
REQ-016 SHALL have port ovf_flag  output  1  signed overflow (ADD/SUB), else 0.
REQ-017 SHALL have port dz_flag  output  1  divide by zero (DIVU/REMU), else 0.

Function
REQ-018 SHALL encode op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0/1), 6 SLL, 7 SRL, 8 SRA (shift by src_b[log2(WIDTH)-1:0]), 9 MUL (low WIDTH bits, unsigned), 10 DIVU, 11 REMU; 12..15 give result 0.
REQ-019 SHALL implement FSM IDLE/BUSY/DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-020 SHALL accept a request on in_valid && in_ready, registering op and operands.
REQ-021 SHALL, for ops 0..8 and 12..15, go IDLE->DONE; out_valid asserted the cycle after acceptance (latency 1).
REQ-022 SHALL, for ops 9..11, go IDLE->BUSY, run WIDTH iterations (shift-add multiply, restoring divide), then BUSY->DONE; out_valid WIDTH+1 cycles after acceptance.
REQ-023 SHALL hold result and all flags stable while out_valid && !out_ready.
REQ-024 SHALL go DONE->IDLE on out_ready; no new request is accepted in that same cycle.
REQ-025 SHALL, for DIVU/REMU with src_b==0, skip iteration, go to DONE with latency 1, result = all-ones (DIVU) or src_a (REMU), dz_flag=1.
REQ-026 SHALL, with MULDIV_EN=0, treat ops 9..11 as undefined (result 0, latency 1).
REQ-027 SHALL ignore in_valid, op and operand changes while BUSY or DONE.
REQ-028 SHALL derive zero_flag and greater_flag from the registered result for every op.

Reset
REQ-029 SHALL, on rst_n low, immediately enter IDLE; result=0, iteration counter=0, carry/ovf/dz=0, out_valid=0, in_ready=1 (zero_flag=1, greater_flag=1 follow result).
REQ-030 SHALL abandon any in-flight MUL/DIV on reset mid-operation with no output produced.

Structure
REQ-031 SHALL place op codes, FSM state type and flag-vector layout in shared package alu_pkg.
REQ-032 SHALL put the iterative multiply/divide datapath in sub-module alu_muldiv_iter (start/done, WIDTH-parameterised).

Verification
REQ-033 SHALL check ADD 0x7FFFFFFF+0x1 (WIDTH=32) -> result 0x80000000, ovf=1, carry=0, greater=0, out_valid one cycle after accept.
REQ-034 SHALL check SUB 5-5 -> result 0, zero=1, carry=1; SLT 0xFFFFFFFF,1 -> result 1.
REQ-035 SHALL check MUL 0x00010000*0x00010000 -> result 0, zero=1, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-036 SHALL check DIVU 100/7 -> 14 and REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF, dz=1, latency 1.
REQ-037 SHALL check out_ready held low 5 cycles after XOR 0xF0F0,0x0FF0 -> result 0xFF00 stable, in_ready=0, then one-cycle handshake returns to IDLE.
REQ-038 SHALL check rst_n pulsed low at iteration 10 of a DIVU -> outputs at reset values immediately, next request accepted normally.
